// File: rtl/fsm_control.sv
// Highway/farm-road traffic light controller with a saturating dwell timer.
// Optional macro FSM_CONTROL_TICK_EN adds Tick_i as the count enable.
module fsm_control #(
    parameter int LONG_T  = 8,
    parameter int SHORT_T = 3,
    parameter int TW      = 4
) (
    input  logic          Clk_i,
    input  logic          Reset_i,
`ifdef FSM_CONTROL_TICK_EN
    input  logic          Tick_i,
`endif
    input  logic          Car_i,
    output logic [1:0]    CurrentState_o,
    output logic          StateChange_o,
    output logic [TW-1:0] Timer_o
);

    typedef enum logic [1:0] {
        HWY_GREEN   = 2'b00,
        HWY_YELLOW  = 2'b01,
        FARM_GREEN  = 2'b10,
        FARM_YELLOW = 2'b11
    } state_t;

    localparam logic [TW-1:0] LONG_LAST  = TW'(LONG_T - 1);
    localparam logic [TW-1:0] SHORT_LAST = TW'(SHORT_T - 1);
    localparam logic [TW-1:0] TIMER_MAX  = '1;

    state_t        state;
    state_t        next_state;
    logic          car_meta;
    logic          car_sync;
    logic          count_en;
    logic [TW-1:0] timer;
    logic          state_change;

`ifdef FSM_CONTROL_TICK_EN
    assign count_en = Tick_i;
`else
    assign count_en = 1'b1;
`endif

    // Car_i is asynchronous; only the second flop may feed decisions.
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            car_meta <= 1'b0;
            car_sync <= 1'b0;
        end else begin
            car_meta <= Car_i;
            car_sync <= car_meta;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            HWY_GREEN:
                if (count_en && car_sync && (timer >= LONG_LAST))
                    next_state = HWY_YELLOW;
            HWY_YELLOW:
                if (count_en && (timer == SHORT_LAST))
                    next_state = FARM_GREEN;
            FARM_GREEN:
                if (count_en && (!car_sync || (timer == LONG_LAST)))
                    next_state = FARM_YELLOW;
            FARM_YELLOW:
                if (count_en && (timer == SHORT_LAST))
                    next_state = HWY_GREEN;
            default:
                next_state = HWY_GREEN;
        endcase
    end

    // The timer restarts from zero in the first cycle of every new state.
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            state        <= HWY_GREEN;
            timer        <= '0;
            state_change <= 1'b0;
        end else begin
            state        <= next_state;
            state_change <= (next_state != state);
            if (next_state != state)
                timer <= '0;
            else if (count_en && (timer != TIMER_MAX))
                timer <= timer + 1'b1;
        end
    end

    assign CurrentState_o = state;
    assign StateChange_o  = state_change;
    assign Timer_o        = timer;

endmodule

// File: tb/tb_fsm_control.sv
// Directed, table-driven bench for fsm_control (defaults LONG_T=8, SHORT_T=3, TW=4).
// Build with FSM_CONTROL_TICK_EN defined to exercise the tick-enabled variant instead.
module tb_fsm_control;

    localparam int TW = 4;

    typedef struct {
        logic          car;
        logic [1:0]    state;
        logic          sc;
        logic [TW-1:0] timer;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          car;
`ifdef FSM_CONTROL_TICK_EN
    logic          tick;
`endif
    logic [1:0]    cur_state;
    logic          state_change;
    logic [TW-1:0] timer_val;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    fsm_control #(.LONG_T(8), .SHORT_T(3), .TW(TW)) dut (
        .Clk_i          (clk),
        .Reset_i        (rst),
`ifdef FSM_CONTROL_TICK_EN
        .Tick_i         (tick),
`endif
        .Car_i          (car),
        .CurrentState_o (cur_state),
        .StateChange_o  (state_change),
        .Timer_o        (timer_val)
    );

    always #5 clk = ~clk;

    task automatic addSegment(input logic c, input logic [1:0] st, input int first_timer,
                              input int len, input logic first_pulse);
        vec_t v;
        for (int i = 0; i < len; i++) begin
            v.car   = c;
            v.state = st;
            v.sc    = (i == 0) && first_pulse;
            v.timer = TW'(first_timer + i);
            vecs.push_back(v);
        end
    endtask

    task automatic applyStimulus(input logic car_in);
        car = car_in;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [1:0] es, input logic esc,
                               input logic [TW-1:0] et);
        checks++;
        if (cur_state !== es || state_change !== esc || timer_val !== et) begin
            errors++;
            $display("[TB] FAIL %s: got state=%0d pulse=%0d timer=%0d, expected state=%0d pulse=%0d timer=%0d",
                     name, cur_state, state_change, timer_val, es, esc, et);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic waitFor(input logic [1:0] es, input logic [TW-1:0] et, input int budget);
        int n;
        n = 0;
        while (!(cur_state === es && timer_val === et) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!(cur_state === es && timer_val === et)) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_timeout: got state=%0d timer=%0d, expected state=%0d timer=%0d",
                     cur_state, timer_val, es, et);
        end
    endtask

`ifndef FSM_CONTROL_TICK_EN
    initial begin
        rst = 1'b0;
        car = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("reset_async", 2'd0, 1'b0, 4'd0);
        @(posedge clk);
        #1;
        checkOutput("reset_held", 2'd0, 1'b0, 4'd0);
        rst = 1'b0;

        // No car: stay in highway green, timer saturates at 15.
        for (int k = 1; k <= 50; k++) begin
            applyStimulus(1'b0);
            checkOutput($sformatf("idle_cycle%0d", k), 2'd0, 1'b0, TW'((k > 15) ? 15 : k));
        end
        checkOutput("timer_saturated", 2'd0, 1'b0, 4'd15);

        // Car arrives with timer saturated: yellow on the third edge.
        applyStimulus(1'b1);
        checkOutput("car_rise_e1", 2'd0, 1'b0, 4'd15);
        applyStimulus(1'b1);
        checkOutput("car_rise_e2", 2'd0, 1'b0, 4'd15);
        applyStimulus(1'b1);
        checkOutput("car_rise_e3", 2'd1, 1'b1, 4'd0);
        applyStimulus(1'b1);
        checkOutput("s1_t1", 2'd1, 1'b0, 4'd1);
        applyStimulus(1'b1);
        checkOutput("s1_t2", 2'd1, 1'b0, 4'd2);
        applyStimulus(1'b1);
        checkOutput("s2_enter", 2'd2, 1'b1, 4'd0);
        applyStimulus(1'b1);
        checkOutput("s2_t1", 2'd2, 1'b0, 4'd1);
        applyStimulus(1'b1);
        checkOutput("s2_t2", 2'd2, 1'b0, 4'd2);

        // Car leaves at S2 timer 2: farm yellow on the third edge.
        applyStimulus(1'b0);
        checkOutput("car_fall_e1", 2'd2, 1'b0, 4'd3);
        applyStimulus(1'b0);
        checkOutput("car_fall_e2", 2'd2, 1'b0, 4'd4);
        applyStimulus(1'b0);
        checkOutput("car_fall_e3", 2'd3, 1'b1, 4'd0);
        applyStimulus(1'b0);
        checkOutput("s3_t1", 2'd3, 1'b0, 4'd1);
        applyStimulus(1'b0);
        checkOutput("s3_t2", 2'd3, 1'b0, 4'd2);
        applyStimulus(1'b0);
        checkOutput("s0_return", 2'd0, 1'b1, 4'd0);

        // Reset pulsed between edges while in S2.
        car = 1'b1;
        waitFor(2'd2, 4'd3, 60);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("reset_mid_s2", 2'd0, 1'b0, 4'd0);
        @(posedge clk);
        #1;
        checkOutput("reset_mid_held", 2'd0, 1'b0, 4'd0);
        rst = 1'b0;

        // Car held through reset release: 8/3/8/3 cycle with 22-cycle period.
        addSegment(1'b1, 2'd0, 1, 7, 1'b0);
        addSegment(1'b1, 2'd1, 0, 3, 1'b1);
        addSegment(1'b1, 2'd2, 0, 8, 1'b1);
        addSegment(1'b1, 2'd3, 0, 3, 1'b1);
        addSegment(1'b1, 2'd0, 0, 8, 1'b1);
        addSegment(1'b1, 2'd1, 0, 3, 1'b1);
        addSegment(1'b1, 2'd2, 0, 8, 1'b1);
        addSegment(1'b1, 2'd3, 0, 3, 1'b1);
        addSegment(1'b1, 2'd0, 0, 2, 1'b1);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].car);
            checkOutput($sformatf("cycle_vec%0d", i), vecs[i].state, vecs[i].sc, vecs[i].timer);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
`else
    int tick_cnt = 0;

    // Tick is high in every fourth clock cycle.
    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tick_cnt++;
            tick = ((tick_cnt % 4) == 0);
        end
    end

    task automatic measureSpan(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (state_change !== 1'b1 && n < 400);
    endtask

    initial begin
        int span;
        int guard;
        rst = 1'b0;
        car = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("reset_async", 2'd0, 1'b0, 4'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        guard = 0;
        while (!(state_change === 1'b1 && cur_state === 2'd1) && guard < 400) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkValue("first_s1_entry", int'(cur_state), 1);
        for (int r = 0; r < 2; r++) begin
            measureSpan(span);
            checkValue($sformatf("s1_span%0d", r), span, 12);
            measureSpan(span);
            checkValue($sformatf("s2_span%0d", r), span, 32);
            measureSpan(span);
            checkValue($sformatf("s3_span%0d", r), span, 12);
            measureSpan(span);
            checkValue($sformatf("s0_span%0d", r), span, 32);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fsm_control.md
FSM_CONTROL -- requirements
Module: fsm_control

Interface
REQ-001 The block SHALL have parameter LONG_T, default 8, giving the highway minimum green and the farm maximum green in timer counts.
REQ-002 The block SHALL have parameter SHORT_T, default 3, giving the yellow dwell in timer counts.
REQ-003 The block SHALL have parameter TW, default 4, giving the timer width in bits.
REQ-004 The block SHALL have port Clk_i, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port Reset_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port Car_i, input, 1 bit: farm-road vehicle sensor, asynchronous to Clk_i.
REQ-007 The block SHALL have port CurrentState_o, output, 2 bits: the current state, which drives the light decoder.
REQ-008 The block SHALL have port StateChange_o, output, 1 bit: a one-cycle pulse in the first cycle of each new state.
REQ-009 The block SHALL have port Timer_o, output, TW bits: the current dwell timer value.

Function
REQ-010 The block SHALL use a state encoding of S0=00 (highway green, farm red), S1=01 (highway yellow), S2=10 (farm green, highway red), S3=11 (farm yellow).
REQ-011 The block SHALL pass Car_i through a two-flop synchronizer (CarSync); every decision SHALL use only CarSync.
REQ-012 The timer SHALL load 0 on every state transition, otherwise advance by one per count enable, and saturate at 2^TW-1.
REQ-013 The count enable SHALL be every clock when the TICK_EN feature (REQ-022) is compiled out.
REQ-014 In S0 the block SHALL move to S1 when Timer_o >= LONG_T-1, CarSync=1 and the count is enabled; otherwise it SHALL hold S0 indefinitely.
REQ-015 In S1 the block SHALL move to S2 when Timer_o = SHORT_T-1 and the count is enabled, so S1 lasts exactly SHORT_T counts.
REQ-016 In S2 the block SHALL move to S3 when the count is enabled and either CarSync=0 or Timer_o = LONG_T-1.
REQ-017 When CarSync=0 and Timer_o = LONG_T-1 occur together in S2, the block SHALL take a single transition to S3.
REQ-018 In S3 the block SHALL move to S0 when Timer_o = SHORT_T-1 and the count is enabled.
REQ-019 StateChange_o SHALL be registered and SHALL be high exactly in the cycle CurrentState_o first shows a new value.
REQ-020 The parameter constraints are SHORT_T >= 1, LONG_T >= SHORT_T and LONG_T <= 2^TW; behaviour outside these bounds is undefined.
REQ-021 The illegal-state path SHALL NOT exist: all four encodings are legal, and any unreachable decode SHALL force S0.

Configuration
REQ-022 When macro FSM_CONTROL_TICK_EN is defined, the block SHALL add input port Tick_i (1 bit), and the count enable SHALL equal Tick_i.
REQ-023 With FSM_CONTROL_TICK_EN defined, transitions and timer increments SHALL occur only in cycles where Tick_i=1.
REQ-024 When FSM_CONTROL_TICK_EN is not defined, port Tick_i SHALL be absent and the count enable SHALL be tied to 1.

Reset
REQ-025 While Reset_i=1, the block SHALL immediately, without a clock edge, drive CurrentState_o=00, Timer_o=0 and StateChange_o=0, and clear both synchronizer flops.
REQ-026 A reset asserted mid-state SHALL abandon the current dwell.
REQ-027 After reset release, the first clock edge SHALL begin S0 timing from 0, and StateChange_o SHALL NOT pulse for the reset-entry to S0.

Verification
REQ-028 The bench SHALL cover: defaults, Car_i=0 for 50 cycles after reset -> CurrentState_o stays 00, StateChange_o never pulses, Timer_o saturates at 15.
REQ-029 The bench SHALL cover: Car_i=1 held from before reset release -> S0 8 cycles, S1 3, S2 8 (farm maximum), S3 3, repeating with a 22-cycle period, and StateChange_o pulsing once at each entry.
REQ-030 The bench SHALL cover: in S0 with the timer saturated, Car_i rises -> CurrentState_o=01 on the third rising edge after the rise.
REQ-031 The bench SHALL cover: in S2 at Timer_o=2, Car_i falls -> CurrentState_o=11 on the third edge after the fall, then S3 lasts 3 cycles, then 00.
REQ-032 The bench SHALL cover: Reset_i pulsed mid-S2 between clock edges -> CurrentState_o=00 and Timer_o=0 before the next edge.
REQ-033 The bench SHALL cover: with FSM_CONTROL_TICK_EN defined and Tick_i high every 4th cycle, Car_i=1 -> S1 spans 12 clock cycles and S0 spans 32 clock cycles.
